// File: rtl/f_d_pipe_reg.sv
// f_d_pipe_reg: fetch-to-decode pipeline register with stall, flush and exception/interrupt override
module f_d_pipe_reg #(
   parameter logic [31:0] PC_RESET   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_LO      = 32'h0000_3000,
   parameter logic [31:0] IM_HI      = 32'h0000_6FFC,
   parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] F_PC,
   input  logic [31:0] F_Instr,
   input  logic        F_BD,
   input  logic        HCU_EN_FD,
   input  logic        flush,
   input  logic        req,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic [4:0]  D_ExcCode,
   output logic        D_BD,
   output logic        D_valid
);
   logic f_exc;
   assign f_exc = (|F_PC[1:0]) || (F_PC < IM_LO) || (F_PC > IM_HI);
   // a flushed slot keeps F_PC so the architectural PC stays monotonic
   always_ff @(posedge clk)
      if (reset) begin
         D_PC      <= PC_RESET;
         D_Instr   <= 32'd0;
         D_ExcCode <= 5'd0;
         D_BD      <= 1'b0;
         D_valid   <= 1'b0;
      end else if (req) begin
         D_PC      <= HANDLER_PC;
         D_Instr   <= 32'd0;
         D_ExcCode <= 5'd0;
         D_BD      <= 1'b0;
         D_valid   <= 1'b0;
      end else if (HCU_EN_FD) begin
         D_PC      <= F_PC;
         D_Instr   <= (flush || f_exc) ? 32'd0 : F_Instr;
         D_ExcCode <= (!flush && f_exc) ? EXC_ADEL : 5'd0;
         D_BD      <= !flush && F_BD;
         D_valid   <= !flush;
      end
endmodule

// File: tb/tb_f_d_pipe_reg.sv
// tb_f_d_pipe_reg: directed test plan plus randomized traffic against a priority-rule reference model
module tb_f_d_pipe_reg;
   logic        clk = 1'b0;
   logic        reset, F_BD, HCU_EN_FD, flush, req;
   logic [31:0] F_PC, F_Instr;
   logic [31:0] D_PC, D_Instr;
   logic [4:0]  D_ExcCode;
   logic        D_BD, D_valid;
   int          checks = 0, errors = 0;
   logic [31:0] m_pc, m_instr;
   logic [4:0]  m_exc;
   logic        m_bd, m_valid;

   f_d_pipe_reg dut (
      .clk(clk), .reset(reset), .F_PC(F_PC), .F_Instr(F_Instr), .F_BD(F_BD),
      .HCU_EN_FD(HCU_EN_FD), .flush(flush), .req(req),
      .D_PC(D_PC), .D_Instr(D_Instr), .D_ExcCode(D_ExcCode), .D_BD(D_BD), .D_valid(D_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit illegal(input logic [31:0] pc);
      return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
   endfunction

   task automatic cyc(input logic r, q, en, fl, input logic [31:0] pc, ins, input logic bd);
      reset = r; req = q; HCU_EN_FD = en; flush = fl; F_PC = pc; F_Instr = ins; F_BD = bd;
      @(posedge clk);
      if (r) {m_pc, m_instr, m_exc, m_bd, m_valid} = {32'h3000, 32'd0, 5'd0, 1'b0, 1'b0};
      else if (q) {m_pc, m_instr, m_exc, m_bd, m_valid} = {32'h4180, 32'd0, 5'd0, 1'b0, 1'b0};
      else if (!en) ;
      else if (fl) {m_pc, m_instr, m_exc, m_bd, m_valid} = {pc, 32'd0, 5'd0, 1'b0, 1'b0};
      else if (illegal(pc)) {m_pc, m_instr, m_exc, m_bd, m_valid} = {pc, 32'd0, 5'd4, bd, 1'b1};
      else {m_pc, m_instr, m_exc, m_bd, m_valid} = {pc, ins, 5'd0, bd, 1'b1};
      #1;
      check("pc", D_PC, m_pc);
      check("instr", D_Instr, m_instr);
      check("exc", {27'd0, D_ExcCode}, {27'd0, m_exc});
      check("bd", {31'd0, D_BD}, {31'd0, m_bd});
      check("valid", {31'd0, D_valid}, {31'd0, m_valid});
   endtask

   logic [31:0] pcs [8] = '{32'h3000, 32'h6FFC, 32'h7000, 32'h2FFC, 32'h3002, 32'h3001, 32'h0, 32'hFFFF_FFFC};

   initial begin
      cyc(1, 0, 1, 0, 32'h5555, 32'h1234, 1);
      check("rst_pc", D_PC, 32'h3000);
      check("rst_valid", {31'd0, D_valid}, 32'd0);
      cyc(0, 0, 1, 0, 32'h3000, 32'h24010001, 0);
      check("tp1_pc", D_PC, 32'h3000);
      check("tp1_instr", D_Instr, 32'h24010001);
      check("tp1_valid", {31'd0, D_valid}, 32'd1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'h3004 + 4 * i, 32'hAAAA0000 + i, 1);
      check("stall_pc", D_PC, 32'h3000);
      check("stall_instr", D_Instr, 32'h24010001);
      cyc(0, 0, 1, 0, 32'h300C, 32'h11112222, 0);
      check("release_pc", D_PC, 32'h300C);
      cyc(0, 0, 1, 0, 32'h3002, 32'h1, 0);
      check("mis_exc", {27'd0, D_ExcCode}, 32'd4);
      check("mis_instr", D_Instr, 32'd0);
      cyc(0, 0, 1, 0, 32'h7000, 32'h2, 0);
      check("hi_exc", {27'd0, D_ExcCode}, 32'd4);
      cyc(0, 0, 1, 0, 32'h6FFC, 32'h3, 1);
      check("edge_exc", {27'd0, D_ExcCode}, 32'd0);
      check("edge_instr", D_Instr, 32'h3);
      cyc(0, 0, 1, 0, 32'h2FFC, 32'h4, 0);
      check("lo_exc", {27'd0, D_ExcCode}, 32'd4);
      cyc(0, 0, 1, 1, 32'h3010, 32'h5, 1);
      check("flush_pc", D_PC, 32'h3010);
      check("flush_bd", {31'd0, D_BD}, 32'd0);
      check("flush_valid", {31'd0, D_valid}, 32'd0);
      cyc(0, 0, 0, 1, 32'h3020, 32'h6, 1);
      check("stallflush_pc", D_PC, 32'h3010);
      cyc(0, 1, 0, 1, 32'h3030, 32'h7, 1);
      check("req_pc", D_PC, 32'h4180);
      check("req_valid", {31'd0, D_valid}, 32'd0);
      cyc(0, 0, 1, 0, 32'h3040, 32'h8, 1);
      cyc(1, 1, 1, 0, 32'h3050, 32'h9, 1);
      check("rstreq_pc", D_PC, 32'h3000);
      check("rstreq_instr", D_Instr, 32'd0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] pc;
         case ($urandom_range(0, 2))
            0: pc = pcs[$urandom_range(0, 7)];
            1: pc = 32'h3000 + 4 * $urandom_range(0, 16'h0FFF);
            default: pc = $urandom;
         endcase
         cyc($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, pc, $urandom, 1'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/f_d_pipe_reg.md
Name: f_d_pipe_reg

Overview:
- Fetch-to-decode pipeline register, directly downstream of the fetch PC stage.
- Each cycle it captures the fetch-stage PC and instruction, and flags a fetch-address exception.
- Supports hazard stall, flush and exception/interrupt request override.
- Feeds the decode stage the PC, instruction, exception code, delay-slot flag and a valid bit.

Parameters:
- PC_RESET, 32'h0000_3000, D_PC value after reset.
- HANDLER_PC, 32'h0000_4180, D_PC loaded with a bubble on req.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, exception code for an illegal fetch address.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- F_PC  input  32  PC of the instruction being fetched.
- F_Instr  input  32  instruction word read at F_PC.
- F_BD  input  1  fetched instruction sits in a branch delay slot.
- HCU_EN_FD  input  1  hazard-unit enable: 1 = advance, 0 = hold.
- flush  input  1  replace the fetched instruction with a bubble.
- req  input  1  exception/interrupt request; clears the pipeline to the handler.
- D_PC  output  32  registered PC.
- D_Instr  output  32  registered instruction (0 = nop/bubble).
- D_ExcCode  output  5  registered fetch exception code (0 = none).
- D_BD  output  1  registered delay-slot flag.
- D_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- All outputs are registered and update only on the rising edge of clk. Latency is 1 cycle from F_* to D_*.
- Reset (highest priority, synchronous):
  - D_PC=PC_RESET, D_Instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
  - Reset asserted mid-stall or mid-flush overrides both.
- Fetch exception check (combinational, on F_PC):
  - f_exc is true if F_PC[1:0]!=0, F_PC<IM_LO or F_PC>IM_HI. Compare as unsigned 32-bit.
  - Boundary: F_PC=IM_LO and F_PC=IM_HI are legal. IM_HI+4 and IM_LO-4 are illegal.
- Update priority on each edge, from highest to lowest:
  1. reset.
  2. req=1: load the bubble D_PC=HANDLER_PC, D_Instr=0, D_ExcCode=0, D_BD=0, D_valid=0. req overrides HCU_EN_FD=0 and flush.
  3. HCU_EN_FD=0: hold every output unchanged. Stall beats flush, because the flush source in D has not advanced.
  4. flush=1: load D_PC=F_PC, D_Instr=0, D_ExcCode=0, D_BD=0, D_valid=0. The PC is kept so the macroscopic PC stays monotonic.
  5. Normal: D_PC=F_PC, D_BD=F_BD, D_valid=1.
     - If f_exc: D_Instr=0 (instruction suppressed) and D_ExcCode=EXC_ADEL.
     - Otherwise: D_Instr=F_Instr and D_ExcCode=0.
- A multi-cycle stall holds the same values for every stalled cycle. Capture resumes on the first edge with HCU_EN_FD=1.
- The block holds no internal state other than the five output registers. No X may propagate from the register outputs after reset.

Test Plan:
- Reset, then F_PC=0x3000, F_Instr=0x24010001, F_BD=0, HCU_EN_FD=1 -> next edge: D_PC=0x3000, D_Instr=0x24010001, D_ExcCode=0, D_valid=1.
- HCU_EN_FD=0 for 3 cycles while F_PC changes 0x3004 to 0x300C -> D_* hold the 0x3000 values. Release -> D_PC=current F_PC on the next edge.
- F_PC=0x3002; then F_PC=0x7000; then F_PC=0x6FFC -> D_ExcCode=4 with D_Instr=0, then 4 with D_Instr=0, then 0 with D_Instr=F_Instr.
- flush=1 with F_PC=0x3010 and F_BD=1 -> D_PC=0x3010, D_Instr=0, D_BD=0, D_valid=0. Repeat with flush=1 and HCU_EN_FD=0 together -> outputs hold.
- req=1 together with HCU_EN_FD=0 and flush=1 -> D_PC=0x4180, D_Instr=0, D_valid=0.
- reset=1 asserted together with req=1 -> D_PC=0x3000, all other outputs 0.
